// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage branch predictor built around a direct-mapped branch target
// buffer (BTB). Each entry holds valid, tag, target and a 2-bit saturating
// direction counter. Lookup of the fetch PC is purely combinational from the
// registered table. Resolved branches from EX train the table and any wrong
// prediction is flagged with the correct redirect address.
//
// Optional feature macro: BP_PERF_CNT_EN adds two free-running 32-bit
// performance counters (resolved branches, mispredictions).
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   pc                - current fetch PC
//   npc, predictor    - predicted next fetch PC and taken-prediction flag
//   ex_valid          - EX instruction valid (not flushed)
//   ex_pc             - PC of the EX instruction
//   ex_is_branch      - EX instruction is a branch or jump
//   ex_taken          - resolved direction
//   ex_target         - resolved target
//   ex_pred_taken     - predictor value carried down the pipe with the instr
//   ex_pred_target    - npc value carried down the pipe with the instr
//   mispredict        - flush request towards IF/ID
//   redirect_pc       - correct next PC, meaningful only while mispredict=1
//   perf_branches     - (BP_PERF_CNT_EN) count of resolved branches
//   perf_mispred      - (BP_PERF_CNT_EN) count of mispredictions
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        predictor,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_hit;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_hit;

    // Fetch-side lookup: pc[1:0] plays no part in index or tag.
    always_comb begin
        rd_idx    = pc[IDX_BITS+1:2];
        rd_tag    = pc[31:IDX_BITS+2];
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        predictor = rd_hit && ctr_q[rd_idx][1];
        npc       = predictor ? target_q[rd_idx] : pc + 32'd4;
    end

    // EX-side resolution. A non-branch that was predicted taken is a BTB
    // alias and must also be flushed.
    always_comb begin
        ex_idx = ex_pc[IDX_BITS+1:2];
        ex_tag = ex_pc[31:IDX_BITS+2];
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

        mispredict = ex_valid &&
            ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)))) ||
             (!ex_is_branch && ex_pred_taken));
        redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
    end

    // Table training. Only the entry at ex_idx can change in a cycle.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (ex_valid) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    if (ex_taken) begin
                        if (ctr_q[ex_idx] != 2'b11) begin
                            ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                        end
                        target_d[ex_idx] = ex_target;
                    end else if (ctr_q[ex_idx] != 2'b00) begin
                        ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
                    end
                end else if (ex_taken) begin
                    // Allocate weakly taken, evicting whatever lived here.
                    valid_d[ex_idx]  = 1'b1;
                    tag_d[ex_idx]    = ex_tag;
                    target_d[ex_idx] = ex_target;
                    ctr_d[ex_idx]    = 2'b10;
                end
            end else if (ex_hit) begin
                valid_d[ex_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispred_q,  perf_mispred_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (ex_valid && ex_is_branch) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (mispredict) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_mispred  = perf_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed steps following the block's intended usage, then randomized
// traffic, all checked against a behavioural BTB model kept in this file.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int IDX_BITS = 4;
    localparam int N        = 1 << IDX_BITS;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        predictor;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .npc            (npc),
        .predictor      (predictor),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches  (perf_branches),
        .perf_mispred   (perf_mispred)
`endif
    );

    // ---------------- reference model ----------------
    int total = 0;
    int bad   = 0;

    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_nbr;
    logic [31:0] m_nmis;

    function automatic int m_idx(logic [31:0] a);
        return int'((a / 32'd4) % N);
    endfunction

    function automatic logic [31:0] m_tag_of(logic [31:0] a);
        return a / (32'd4 * N);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tag_of(a));
    endfunction

    function automatic bit m_pred(logic [31:0] a);
        return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(logic [31:0] a);
        return m_pred(a) ? m_tgt[m_idx(a)] : a + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (!ex_valid) return 1'b0;
        if (ex_is_branch)
            return (ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target));
        return ex_pred_taken;
    endfunction

    function automatic logic [31:0] m_redir();
        return (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_nbr  = '0;
        m_nmis = '0;
    endtask

    task automatic model_update();
        int  i;
        bit  h;
        if (ex_valid && ex_is_branch) m_nbr = m_nbr + 32'd1;
        if (m_mis()) m_nmis = m_nmis + 32'd1;
        if (!ex_valid) return;
        i = m_idx(ex_pc);
        h = m_hit(ex_pc);
        if (ex_is_branch) begin
            if (h) begin
                m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (ex_taken) m_tgt[i] = ex_target;
            end else if (ex_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tag_of(ex_pc);
                m_tgt[i]   = ex_target;
                m_ctr[i]   = 2;
            end
        end else if (h) begin
            m_valid[i] = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(string name);
        check({name, ".predictor"},  {31'b0, predictor},  {31'b0, m_pred(pc)});
        check({name, ".npc"},        npc,                 m_npc(pc));
        check({name, ".mispredict"}, {31'b0, mispredict}, {31'b0, m_mis()});
        if (m_mis()) check({name, ".redirect_pc"}, redirect_pc, m_redir());
`ifdef BP_PERF_CNT_EN
        check({name, ".perf_branches"}, perf_branches, m_nbr);
        check({name, ".perf_mispred"},  perf_mispred,  m_nmis);
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic set_ex(bit v, logic [31:0] a, bit br, bit tk,
                          logic [31:0] tgt, bit pt, logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = a;
        ex_is_branch   = br;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Advance one edge; the model trains on the same edge as the DUT.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_update();
        #1;
    endtask

    function automatic logic [31:0] pick_addr();
        return 32'h100 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
    endfunction

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'h200;
            1:       return 32'h300;
            2:       return 32'h400;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        pc    = 32'h100;
        idle_ex();
        model_reset();
        #12;
        check_all("reset");
        check("reset.npc_lit", npc, 32'h104);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Cold lookup, including wrap of pc+4.
        check_all("cold");
        check("cold.pred_lit", {31'b0, predictor}, 32'd0);
        pc = 32'hFFFF_FFFC;
        #1;
        check("cold.wrap_npc", npc, 32'h0);
        pc = 32'h100;

        // Taken branch miss allocates, then hits.
        set_ex(1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
        #1;
        check_all("alloc");
        check("alloc.redirect_lit", redirect_pc, 32'h200);
        tick();
        idle_ex();
        #1;
        check_all("alloc_hit");
        check("alloc_hit.npc_lit", npc, 32'h200);

        // Hysteresis: 10 -> 01 (not taken), then up to 11, then 10 still taken.
        set_ex(1, 32'h100, 1, 0, 32'h0, 1, 32'h200);
        #1;
        check_all("hys_nt");
        tick();
        idle_ex();
        #1;
        check("hys_nt.pred_lit", {31'b0, predictor}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_ex(1, 32'h100, 1, 1, 32'h200, m_pred(32'h100), m_npc(32'h100));
            #1;
            check_all("hys_t");
            tick();
        end
        set_ex(1, 32'h100, 1, 0, 32'h0, 1, 32'h200);
        tick();
        idle_ex();
        #1;
        check_all("hys_sat");
        check("hys_sat.pred_lit", {31'b0, predictor}, 32'd1);

        // Target change.
        set_ex(1, 32'h100, 1, 1, 32'h300, 1, 32'h200);
        #1;
        check_all("tgt_chg");
        check("tgt_chg.redirect_lit", redirect_pc, 32'h300);
        tick();
        idle_ex();
        #1;
        check("tgt_chg.npc_lit", npc, 32'h300);

        // Alias: same index, different tag, then non-branch invalidation.
        pc = 32'h140;
        #1;
        check_all("alias");
        check("alias.pred_lit", {31'b0, predictor}, 32'd0);
        set_ex(1, 32'h100, 0, 0, 32'h0, 1, 32'h300);
        #1;
        check_all("nonbr");
        check("nonbr.redirect_lit", redirect_pc, 32'h104);
        tick();
        idle_ex();
        pc = 32'h100;
        #1;
        check_all("nonbr_inval");
        check("nonbr_inval.pred_lit", {31'b0, predictor}, 32'd0);

        // Same-index update and lookup: lookup sees old contents.
        set_ex(1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
        tick();
        set_ex(1, 32'h100, 1, 1, 32'h300, 1, 32'h200);
        #1;
        check_all("same_idx_old");
        check("same_idx_old.npc_lit", npc, 32'h200);
        tick();
        idle_ex();
        #1;
        check("same_idx_new.npc_lit", npc, 32'h300);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            pc = pick_addr() | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
            a  = pick_addr();
            if ($urandom_range(0, 3) != 0)
                set_ex($urandom_range(0, 3) != 0, a, $urandom_range(0, 4) != 0,
                       1'($urandom_range(0, 1)), pick_tgt(), m_pred(a), m_npc(a));
            else
                set_ex($urandom_range(0, 3) != 0, a, $urandom_range(0, 4) != 0,
                       1'($urandom_range(0, 1)), pick_tgt(),
                       1'($urandom_range(0, 1)), pick_tgt());
            #1;
            check_all("rand");
            tick();
        end

        // Asynchronous reset mid-cycle.
        set_ex(1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
        tick();
        idle_ex();
        pc = 32'h100;
        #1;
        check("arst_pre.pred_lit", {31'b0, predictor}, 32'd1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("arst");
        check("arst.pred_lit", {31'b0, predictor}, 32'd0);
        check("arst.npc_lit", npc, 32'h104);
`ifdef BP_PERF_CNT_EN
        check("arst.perf_branches_lit", perf_branches, 32'd0);
        check("arst.perf_mispred_lit",  perf_mispred,  32'd0);
`endif
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
